trace_packet_decoder: RTL and testbench

Decodes the tracer's packet stream back into absolute RAM bus events: full address, absolute timestamp, and write data or read-burst summary. It sits at the receiving end of the USB packet stream, for example in a loopback or self-check build fed from a FIFO. It is the exact inverse of the tracing state machine's packet encoding.

---
 rtl/trace_packet_decoder_if.sv | 27 ++
 rtl/trace_packet_decoder.sv | 87 ++++++++
 tb/tb_trace_packet_decoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_packet_decoder_if.sv
// trace_packet_decoder_if: packet input stream and decoded event output of the trace decoder
interface trace_packet_decoder_if #(
    parameter int ADDR_W = 23,
    parameter int TIME_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_type;
    logic [ADDR_W-1:0] in_payload;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_is_read;
    logic [ADDR_W-1:0] ev_addr;
    logic [15:0]       ev_data;
    logic [1:0]        ev_ublb;
    logic [TIME_W-1:0] ev_time;

    modport slave (
        input  in_valid, in_type, in_payload, ev_ready,
        output in_ready, ev_valid, ev_is_read, ev_addr, ev_data, ev_ublb, ev_time
    );

    modport master (
        output in_valid, in_type, in_payload, ev_ready,
        input  in_ready, ev_valid, ev_is_read, ev_addr, ev_data, ev_ublb, ev_time
    );
endinterface

// File: rtl/trace_packet_decoder.sv
// trace_packet_decoder: rebuilds absolute address/time RAM bus events from the tracer packet stream
module trace_packet_decoder #(
    parameter int ADDR_W = 23,
    parameter int TIME_W = 32
) (
    input  logic                  mclk,
    input  logic                  reset,
    trace_packet_decoder_if.slave bus,
    output logic                  synced,
    output logic                  err_unsynced
);
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [TIME_W-1:0] time_acc_q, time_acc_d;
    logic              synced_q, synced_d;
    logic              err_q, err_d;
    logic              ev_valid_q, ev_valid_d;
    logic              ev_is_read_q, ev_is_read_d;
    logic [ADDR_W-1:0] ev_addr_q, ev_addr_d;
    logic [15:0]       ev_data_q, ev_data_d;
    logic [1:0]        ev_ublb_q, ev_ublb_d;
    logic [TIME_W-1:0] ev_time_q, ev_time_d;
    logic              accept, is_data, is_addr, load;
    logic [4:0]        ts5;
    logic [TIME_W-1:0] time_sum;

    // Types 1 and 2 carry data; both share the {ts5, ublb, 16-bit field} layout.
    assign bus.in_ready = !ev_valid_q || bus.ev_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_data      = bus.in_type[0] ^ bus.in_type[1];
    assign is_addr      = bus.in_type == 2'd0;
    assign load         = accept && is_data && synced_q;
    assign ts5          = bus.in_payload[ADDR_W-1 -: 5];
    assign time_sum     = time_acc_q + (is_data ? TIME_W'(ts5) : TIME_W'(bus.in_payload));

    // Next state: address/time tracking, sync flags and the event register load/hold/clear.
    always_comb begin
        cur_addr_d   = (accept && is_addr) ? bus.in_payload
                     : !load               ? cur_addr_q
                     : bus.in_type[0]      ? cur_addr_q + ADDR_W'(bus.in_payload[7:0])
                     :                       cur_addr_q + ADDR_W'(1);
        time_acc_d   = (accept && !is_addr) ? time_sum : time_acc_q;
        synced_d     = synced_q || (accept && is_addr);
        err_d        = err_q || (accept && is_data && !synced_q);
        ev_valid_d   = load || (ev_valid_q && !bus.ev_ready);
        ev_is_read_d = load ? bus.in_type[0] : ev_is_read_q;
        ev_addr_d    = load ? cur_addr_q : ev_addr_q;
        ev_data_d    = load ? bus.in_payload[15:0] : ev_data_q;
        ev_ublb_d    = load ? bus.in_payload[17:16] : ev_ublb_q;
        ev_time_d    = load ? time_sum : ev_time_q;
    end

    // State register; reset discards any in-flight event and clears the sticky error.
    always_ff @(posedge mclk) begin
        if (reset) begin
            cur_addr_q   <= '0;
            time_acc_q   <= '0;
            synced_q     <= 1'b0;
            err_q        <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_is_read_q <= 1'b0;
            ev_addr_q    <= '0;
            ev_data_q    <= '0;
            ev_ublb_q    <= '0;
            ev_time_q    <= '0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            time_acc_q   <= time_acc_d;
            synced_q     <= synced_d;
            err_q        <= err_d;
            ev_valid_q   <= ev_valid_d;
            ev_is_read_q <= ev_is_read_d;
            ev_addr_q    <= ev_addr_d;
            ev_data_q    <= ev_data_d;
            ev_ublb_q    <= ev_ublb_d;
            ev_time_q    <= ev_time_d;
        end
    end

    assign bus.ev_valid   = ev_valid_q;
    assign bus.ev_is_read = ev_is_read_q;
    assign bus.ev_addr    = ev_addr_q;
    assign bus.ev_data    = ev_data_q;
    assign bus.ev_ublb    = ev_ublb_q;
    assign bus.ev_time    = ev_time_q;
    assign synced         = synced_q;
    assign err_unsynced   = err_q;
endmodule

// File: tb/tb_trace_packet_decoder.sv
// tb_trace_packet_decoder: directed packets with a queued scoreboard checked by an event monitor
module tb_trace_packet_decoder;
    localparam int AW = 23;
    localparam int TW = 32;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    ublb;
        logic [TW-1:0] tm;
    } ev_t;

    logic mclk = 1'b0;
    logic reset = 1'b1;
    logic synced, err_unsynced;
    ev_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    trace_packet_decoder_if #(.ADDR_W(AW), .TIME_W(TW)) bus ();

    trace_packet_decoder #(.ADDR_W(AW), .TIME_W(TW)) dut (
        .mclk(mclk),
        .reset(reset),
        .bus(bus),
        .synced(synced),
        .err_unsynced(err_unsynced)
    );

    always #5 mclk = ~mclk;

    function automatic logic [AW-1:0] pk(input logic [4:0] ts, input logic [1:0] u, input logic [15:0] d);
        return {ts, u, d};
    endfunction

    function automatic ev_t mk(input logic rd, input logic [AW-1:0] a, input logic [15:0] d,
                               input logic [1:0] u, input logic [TW-1:0] t);
        return {rd, a, d, u, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge mclk);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string name);
        idle(4);
        chk(name, sb.size(), 0);
    endtask

    task automatic send(input logic [1:0] t, input logic [AW-1:0] p);
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.in_type    = t;
        bus.in_payload = p;
        @(negedge mclk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge mclk);
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: type %0d payload %h never accepted", t, p);
        end
        @(posedge mclk);
        #1 bus.in_valid = 1'b0;
    endtask

    always @(negedge mclk) begin
        ev_t got, exp;
        if (!reset && bus.ev_valid && bus.ev_ready) begin
            got = {bus.ev_is_read, bus.ev_addr, bus.ev_data, bus.ev_ublb, bus.ev_time};
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL event: unexpected event rd=%0d addr=%h data=%h ublb=%0d time=%h",
                         got.rd, got.addr, got.data, got.ublb, got.tm);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL event: got rd=%0d addr=%h data=%h ublb=%0d time=%h expected rd=%0d addr=%h data=%h ublb=%0d time=%h",
                             got.rd, got.addr, got.data, got.ublb, got.tm,
                             exp.rd, exp.addr, exp.data, exp.ublb, exp.tm);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_type    = 2'd0;
        bus.in_payload = '0;
        bus.ev_ready   = 1'b1;
        do_reset();
        @(negedge mclk);
        chk("reset_ev_valid", bus.ev_valid, 0);
        chk("reset_synced", synced, 0);
        chk("reset_err", err_unsynced, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        sync();

        // address then write, then a follow-on write to see the advanced address
        send(2'd0, 23'h001000);
        sb.push_back(mk(1'b0, 23'h001000, 16'hBEEF, 2'd3, 32'd4));
        send(2'd2, pk(5'd4, 2'd3, 16'hBEEF));
        sb.push_back(mk(1'b0, 23'h001001, 16'h0001, 2'd1, 32'd4));
        send(2'd2, pk(5'd0, 2'd1, 16'h0001));
        @(negedge mclk);
        chk("addr_synced", synced, 1);
        sync();
        drain("drain_write");

        // timestamp then read burst then write
        do_reset();
        send(2'd0, 23'h000200);
        send(2'd3, 23'd100);
        sb.push_back(mk(1'b1, 23'h000200, 16'h5A08, 2'd2, 32'd131));
        send(2'd1, pk(5'd31, 2'd2, 16'h5A08));
        sb.push_back(mk(1'b0, 23'h000208, 16'h1234, 2'd3, 32'd132));
        send(2'd2, pk(5'd1, 2'd3, 16'h1234));
        drain("drain_read");

        // data before any address: no event, sticky error
        do_reset();
        send(2'd2, pk(5'd7, 2'd3, 16'hAAAA));
        @(negedge mclk);
        chk("unsync_no_event", bus.ev_valid, 0);
        chk("unsync_err", err_unsynced, 1);
        chk("unsync_synced", synced, 0);
        sync();
        send(2'd0, 23'h000010);
        sb.push_back(mk(1'b0, 23'h000010, 16'h5555, 2'd1, 32'd9));
        send(2'd2, pk(5'd2, 2'd1, 16'h5555));
        @(negedge mclk);
        chk("unsync_err_sticky", err_unsynced, 1);
        chk("unsync_then_synced", synced, 1);
        sync();
        drain("drain_unsync");

        // backpressure: consumer stalls for 5 cycles with two packets waiting
        do_reset();
        bus.ev_ready = 1'b0;
        send(2'd0, 23'h000300);
        sb.push_back(mk(1'b0, 23'h000300, 16'h1111, 2'd3, 32'd1));
        sb.push_back(mk(1'b0, 23'h000301, 16'h2222, 2'd2, 32'd3));
        sb.push_back(mk(1'b0, 23'h000302, 16'h3333, 2'd1, 32'd6));
        send(2'd2, pk(5'd1, 2'd3, 16'h1111));
        fork
            begin
                send(2'd2, pk(5'd2, 2'd2, 16'h2222));
                send(2'd2, pk(5'd3, 2'd1, 16'h3333));
            end
        join_none
        repeat (5) begin
            @(negedge mclk);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_ev_valid", bus.ev_valid, 1);
            chk("stall_ev_addr", bus.ev_addr, 32'h000300);
            chk("stall_ev_data", bus.ev_data, 32'h1111);
            chk("stall_ev_time", bus.ev_time, 1);
        end
        sync();
        bus.ev_ready = 1'b1;
        wait fork;
        drain("drain_stall");

        // address and time wrap
        do_reset();
        send(2'd0, 23'h7FFFFF);
        sb.push_back(mk(1'b0, 23'h7FFFFF, 16'hA001, 2'd3, 32'd0));
        send(2'd2, pk(5'd0, 2'd3, 16'hA001));
        sb.push_back(mk(1'b0, 23'h000000, 16'hA002, 2'd3, 32'd0));
        send(2'd2, pk(5'd0, 2'd3, 16'hA002));
        send(2'd0, 23'h7FFFFE);
        sb.push_back(mk(1'b1, 23'h7FFFFE, 16'h1103, 2'd0, 32'd0));
        send(2'd1, pk(5'd0, 2'd0, 16'h1103));
        sb.push_back(mk(1'b0, 23'h000001, 16'hA003, 2'd3, 32'd0));
        send(2'd2, pk(5'd0, 2'd3, 16'hA003));
        for (int i = 0; i < 512; i++) send(2'd3, 23'h7FFFFF);
        send(2'd3, 23'h000300);
        sb.push_back(mk(1'b0, 23'h000002, 16'hD00D, 2'd2, 32'h00000105));
        send(2'd2, pk(5'd5, 2'd2, 16'hD00D));
        drain("drain_wrap");

        // reset while an event is held by a stalled consumer
        do_reset();
        bus.ev_ready = 1'b0;
        send(2'd0, 23'h000040);
        send(2'd2, pk(5'd9, 2'd3, 16'hCAFE));
        @(negedge mclk);
        chk("mid_ev_valid_before", bus.ev_valid, 1);
        reset = 1'b1;
        @(posedge mclk);
        #1 reset = 1'b0;
        @(negedge mclk);
        chk("mid_ev_valid", bus.ev_valid, 0);
        chk("mid_synced", synced, 0);
        chk("mid_in_ready", bus.in_ready, 1);
        chk("mid_ev_addr", bus.ev_addr, 0);
        chk("mid_ev_data", bus.ev_data, 0);
        chk("mid_ev_ublb", bus.ev_ublb, 0);
        chk("mid_ev_time", bus.ev_time, 0);
        chk("mid_ev_is_read", bus.ev_is_read, 0);
        chk("mid_err", err_unsynced, 0);
        sync();
        bus.ev_ready = 1'b1;
        drain("drain_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
